// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared types and constants for the switch demux register bank
package sw_pkg;

    // Debouncer FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        COMMIT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // 5 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE = 250000;

    // Destination select encoding
    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/sw_demux_regbank_if.sv
// rtl/sw_demux_regbank_if.sv - switch/key inputs and register outputs of the demux register bank
//
// master : drives data_in, sel, key_n, clr; observes out0/out1, valid0/valid1, load_pulse, busy
// slave  : the register bank itself
interface sw_demux_regbank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             sel;
    logic             key_n;
    logic             clr;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             valid0;
    logic             valid1;
    logic             load_pulse;
    logic             busy;

    modport master (
        output data_in, sel, key_n, clr,
        input  out0, out1, valid0, valid1, load_pulse, busy
    );

    modport slave (
        input  data_in, sel, key_n, clr,
        output out0, out1, valid0, valid1, load_pulse, busy
    );
endinterface

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - key synchronizer, debounce counter and press/release FSM
//
// clk, rst_n   : clock, asynchronous active-low reset
// key_n        : raw active-low pushbutton (asynchronous, bouncy)
// press_commit : high for the single COMMIT-state cycle of an accepted press
// busy         : high whenever the FSM is outside IDLE
module key_debouncer
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_commit,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             key_s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // State register; synchronizer resets to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            key_s <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            key_s <= sync1;
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state. The IDLE cycle that first sees the key low counts as the
    // first stable cycle, so a press needs DEBOUNCE_CYCLES low samples in total.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_next = PRESS;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            PRESS: begin
                if (key_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = COMMIT;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            COMMIT: begin
                state_next = RELEASE;
                cnt_next   = '0;
            end
            RELEASE: begin
                // Any low sample restarts the release window, so a held key
                // never returns to IDLE and never commits twice.
                if (!key_s) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        press_commit = (state == COMMIT);
        busy         = (state != IDLE);
    end

endmodule

// File: rtl/sw_demux_regbank.sv
// rtl/sw_demux_regbank.sv - debounced key stores the switch word into one of two registers
//
// clk, rst_n : clock, asynchronous active-low reset
// bus        : slave side of sw_demux_regbank_if
//              data_in/sel sampled in the COMMIT cycle, key_n raw key, clr synchronous clear,
//              out0/out1 registers, valid0/valid1 written flags, load_pulse commit strobe, busy
module sw_demux_regbank
    import sw_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    sw_demux_regbank_if.slave   bus
);

    logic             press_commit;
    logic             busy;
    logic [WIDTH-1:0] out0_q;
    logic [WIDTH-1:0] out1_q;
    logic             valid0_q;
    logic             valid1_q;
    logic             load_pulse_q;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_debouncer (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_n        (bus.key_n),
        .press_commit (press_commit),
        .busy         (busy)
    );

    // clr wins over a simultaneous commit; load_pulse still reports the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_q       <= '0;
            out1_q       <= '0;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            load_pulse_q <= 1'b0;
        end else begin
            load_pulse_q <= press_commit;
            if (bus.clr) begin
                out0_q   <= '0;
                out1_q   <= '0;
                valid0_q <= 1'b0;
                valid1_q <= 1'b0;
            end else if (press_commit) begin
                if (bus.sel == SEL_OUT0) begin
                    out0_q   <= bus.data_in;
                    valid0_q <= 1'b1;
                end else begin
                    out1_q   <= bus.data_in;
                    valid1_q <= 1'b1;
                end
            end
        end
    end

    assign bus.out0       = out0_q;
    assign bus.out1       = out1_q;
    assign bus.valid0     = valid0_q;
    assign bus.valid1     = valid1_q;
    assign bus.load_pulse = load_pulse_q;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_sw_demux_regbank.sv
// tb/tb_sw_demux_regbank.sv - self-checking bench for sw_demux_regbank
module tb_sw_demux_regbank;

    localparam int W = 4;
    localparam int D = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    sw_demux_regbank_if #(.WIDTH(W)) bus ();

    sw_demux_regbank #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         sel;
        logic         clr_c;
        logic         late_en;
        logic [W-1:0] late;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic         v0;
        logic         v1;
    } row_t;

    row_t         rows[7];
    logic [W-1:0] prev0;
    logic [W-1:0] prev1;
    logic         prev_v0;
    logic         prev_v1;

    // Clean press of 10 cycles; commit lands on the 7th edge after key_n falls.
    task automatic do_press(input row_t r, input int idx);
        @(negedge clk);
        bus.data_in = r.data;
        bus.sel     = r.sel;
        bus.key_n   = 1'b0;
        bus.clr     = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) begin
                check($sformatf("row%0d_pre_out", idx),
                      {bus.out0, bus.out1, bus.valid0, bus.valid1, bus.load_pulse},
                      {prev0, prev1, prev_v0, prev_v1, 1'b0});
                check($sformatf("row%0d_busy", idx), bus.busy, 1'b1);
            end
            if (i == 7) begin
                check($sformatf("row%0d_out", idx),
                      {bus.out0, bus.out1, bus.valid0, bus.valid1, bus.load_pulse},
                      {r.e0, r.e1, r.v0, r.v1, 1'b1});
            end
            if (i == 8) check($sformatf("row%0d_lp_end", idx), bus.load_pulse, 1'b0);
            @(negedge clk);
            if (i == 6 && r.clr_c) bus.clr = 1'b1;
            if (i == 7) bus.clr = 1'b0;
            if (i == 8 && r.late_en) bus.data_in = r.late;
            if (i == 10) bus.key_n = 1'b1;
        end
        repeat (D + 4) @(posedge clk);
        #1;
        check($sformatf("row%0d_final", idx),
              {bus.out0, bus.out1, bus.valid0, bus.valid1, bus.busy},
              {r.e0, r.e1, r.v0, r.v1, 1'b0});
        prev0   = r.e0;
        prev1   = r.e1;
        prev_v0 = r.v0;
        prev_v1 = r.v1;
    endtask

    // Randomized phase: key plan built as clean presses and short bounces.
    int            plan[$];
    bit            wr_at[int];
    logic [W-1:0]  m_reg[2];
    logic          m_val[2];

    initial begin
        int lp_cnt;
        n_cmp = 0;
        n_bad = 0;
        rst_n       = 1'b0;
        bus.key_n   = 1'b1;
        bus.data_in = '0;
        bus.sel     = 1'b0;
        bus.clr     = 1'b0;

        rows[0] = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0011, 4'b0000, 1'b1, 1'b0};
        rows[1] = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0};
        rows[2] = '{4'b0111, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0111, 1'b1, 1'b1};
        rows[3] = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b1};
        rows[4] = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'b1010, 4'b0101, 4'b1000, 1'b1, 1'b1};
        rows[5] = '{4'b1100, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        rows[6] = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110, 4'b0000, 1'b1, 1'b0};

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_out", {bus.out0, bus.out1, bus.valid0, bus.valid1}, '0);
        check("reset_busy_lp", {bus.busy, bus.load_pulse}, 2'b00);
        prev0 = '0; prev1 = '0; prev_v0 = 1'b0; prev_v1 = 1'b0;

        for (int r = 0; r < 7; r++) do_press(rows[r], r);

        // Bounce: low 2, high 1, low 2, high
        @(negedge clk);
        lp_cnt = 0;
        bus.key_n = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == 2) bus.key_n = 1'b1;
            if (i == 3) bus.key_n = 1'b0;
            if (i == 5) bus.key_n = 1'b1;
            @(posedge clk);
            #1;
            if (bus.load_pulse) lp_cnt++;
            @(negedge clk);
        end
        check("bounce_no_commit", lp_cnt, 0);
        check("bounce_out", {bus.out0, bus.out1, bus.valid0, bus.valid1, bus.busy},
              {4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0});

        // Key held 30 cycles: one commit only
        lp_cnt = 0;
        bus.data_in = 4'b0010;
        bus.sel     = 1'b1;
        bus.key_n   = 1'b0;
        for (int i = 0; i < 30 + D + 8; i++) begin
            if (i == 30) bus.key_n = 1'b1;
            @(posedge clk);
            #1;
            if (bus.load_pulse) lp_cnt++;
            @(negedge clk);
        end
        check("hold_one_pulse", lp_cnt, 1);
        check("hold_out", {bus.out0, bus.out1, bus.valid0, bus.valid1, bus.busy},
              {4'b0110, 4'b0010, 1'b1, 1'b1, 1'b0});

        // Reset asserted mid-PRESS
        bus.data_in = 4'b1111;
        bus.sel     = 1'b0;
        bus.key_n   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midpress_busy", bus.busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midpress_rst_now", {bus.busy, bus.out0, bus.out1, bus.valid0, bus.valid1}, '0);
        bus.key_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lp_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.load_pulse) lp_cnt++;
        end
        check("midpress_no_write", {bus.out0, bus.valid0, bus.busy, 32'(lp_cnt)} , '0);

        // Randomized: each accepted press of L>=D lows starting at plan edge s
        // writes at edge s+D+2 using that edge's data/sel; shorter runs never write.
        for (int i = 0; i < 6; i++) plan.push_back(1);
        for (int t = 0; t < 30; t++) begin
            int s;
            int len;
            s = plan.size();
            if ($urandom_range(3) == 0) begin
                len = 1 + $urandom_range(D - 2);
                for (int i = 0; i < len; i++) plan.push_back(0);
                len = 1 + $urandom_range(2);
                for (int i = 0; i < len; i++) plan.push_back(1);
            end else begin
                len = D + $urandom_range(7);
                for (int i = 0; i < len; i++) plan.push_back(0);
                wr_at[s + D + 2] = 1'b1;
                len = D + 2 + $urandom_range(3);
                for (int i = 0; i < len; i++) plan.push_back(1);
            end
        end
        for (int i = 0; i < D + 6; i++) plan.push_back(1);

        m_reg[0] = '0; m_reg[1] = '0;
        m_val[0] = 1'b0; m_val[1] = 1'b0;
        for (int e = 0; e < plan.size(); e++) begin
            logic lp_exp;
            int   sidx;
            @(negedge clk);
            bus.key_n   = plan[e][0];
            bus.data_in = W'($urandom);
            bus.sel     = 1'($urandom);
            bus.clr     = ($urandom_range(11) == 0);
            @(posedge clk);
            #1;
            lp_exp = wr_at.exists(e);
            sidx   = int'(bus.sel);
            if (bus.clr) begin
                m_reg[0] = '0; m_reg[1] = '0;
                m_val[0] = 1'b0; m_val[1] = 1'b0;
            end else if (lp_exp) begin
                m_reg[sidx] = bus.data_in;
                m_val[sidx] = 1'b1;
            end
            check($sformatf("rand_e%0d", e),
                  {bus.out0, bus.out1, bus.valid0, bus.valid1, bus.load_pulse},
                  {m_reg[0], m_reg[1], m_val[0], m_val[1], lp_exp});
        end
        @(negedge clk);
        bus.clr = 1'b0;
        @(posedge clk);
        #1;
        check("rand_idle_end", bus.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
